// File: rtl/bcd_counter_display.sv
// bcd_counter_display: NUM_DIGITS-wide BCD up/down counter stepped by tick
// rising edges, plus a registered scan-position decoder that reports the
// digit under the VGA beam, its glyph-ROM pixel address and an enable.
module bcd_counter_display #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int NUM_DIGITS        = 3,
  parameter int X0                = 179,
  parameter int Y0                = 466,
  parameter int DIGIT_W           = 12,
  parameter int DIGIT_H           = 10,
  parameter int GAP               = 2,
  parameter int ADDR_W            = 8,
  parameter int SATURATE          = 0,
  parameter int BLANK_LEADING     = 0
) (
  input  logic                         clock_25,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         load,
  input  logic [4*NUM_DIGITS-1:0]      load_value,
  input  logic                         tick,
  input  logic                         count_down,
  input  logic                         hold,
  input  logic [PIXEL_DISPLAY_BIT:0]   X,
  input  logic [PIXEL_DISPLAY_BIT:0]   Y,
  output logic [4*NUM_DIGITS-1:0]      bcd_value,
  output logic                         terminal,
  output logic [3:0]                   selected_number,
  output logic [ADDR_W-1:0]            glyph_addr,
  output logic                         en_digit
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [BW-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};
  localparam logic [BW-1:0] ALL_ZEROS = {BW{1'b0}};

  // Counter state and next state
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_d;
  logic              terminal_q;
  logic              terminal_d;
  logic              tick_prev_q;
  logic              step_s;

  // Render state and next state
  logic [3:0]        sel_q;
  logic [3:0]        sel_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              en_q;
  logic              en_d;

  // Render helpers
  logic [NUM_DIGITS-1:0] blank_s;
  logic                  lead_zero_s;
  int                    x_s;
  int                    y_s;
  int                    xi_s;
  int                    off_s;

  // Nibble j counts from the least-significant digit (bits [3:0]).
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (c) begin
        if (v[4*j +: 4] >= 4'd9) begin
          r[4*j +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[4*j +: 4] = v[4*j +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*j +: 4] = v[4*j +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (b) begin
        if (v[4*j +: 4] == 4'd0) begin
          r[4*j +: 4] = 4'd9;
          b = 1'b1;
        end else begin
          r[4*j +: 4] = v[4*j +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*j +: 4] = v[4*j +: 4];
      end
    end
    return r;
  endfunction

  // Out-of-range nibbles on load become 9 so the counter only holds BCD.
  function automatic logic [BW-1:0] bcd_clamp(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (v[4*j +: 4] > 4'd9) begin
        r[4*j +: 4] = 4'd9;
      end else begin
        r[4*j +: 4] = v[4*j +: 4];
      end
    end
    return r;
  endfunction

  // A hold-time edge is dropped outright rather than remembered.
  assign step_s = tick & ~tick_prev_q & ~hold;

  // Counter next state: clear beats load beats a step; saturated steps do not pulse.
  always_comb begin
    bcd_d      = bcd_q;
    terminal_d = 1'b0;
    if (clear) begin
      bcd_d = ALL_ZEROS;
    end else if (load) begin
      bcd_d = bcd_clamp(load_value);
    end else if (step_s) begin
      if (count_down) begin
        if ((bcd_q == ALL_ZEROS) && (SATURATE != 0)) begin
          bcd_d = bcd_q;
        end else begin
          bcd_d      = bcd_dec(bcd_q);
          terminal_d = (bcd_dec(bcd_q) == ALL_ZEROS);
        end
      end else begin
        if ((bcd_q == ALL_NINES) && (SATURATE != 0)) begin
          bcd_d = bcd_q;
        end else begin
          bcd_d      = bcd_inc(bcd_q);
          terminal_d = (bcd_inc(bcd_q) == ALL_NINES);
        end
      end
    end else begin
      bcd_d = bcd_q;
    end
  end

  // Leading-zero mask: digit i is blankable while it and all digits left of it are 0.
  always_comb begin
    lead_zero_s = 1'b1;
    blank_s     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_zero_s = lead_zero_s & (bcd_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if ((BLANK_LEADING != 0) && lead_zero_s && (i != NUM_DIGITS - 1)) begin
        blank_s[i] = 1'b1;
      end else begin
        blank_s[i] = 1'b0;
      end
    end
  end

  // Box decode from the current X/Y alone, so any scan order renders correctly.
  always_comb begin
    en_d   = 1'b0;
    sel_d  = 4'd0;
    addr_d = '0;
    x_s    = {{(31-PIXEL_DISPLAY_BIT){1'b0}}, X};
    y_s    = {{(31-PIXEL_DISPLAY_BIT){1'b0}}, Y};
    xi_s   = 0;
    off_s  = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      xi_s = X0 + i * (DIGIT_W + GAP);
      if ((x_s >= xi_s) && (x_s <= xi_s + DIGIT_W - 1) &&
          (y_s >= Y0) && (y_s <= Y0 + DIGIT_H - 1) && !blank_s[i]) begin
        off_s  = (y_s - Y0) * DIGIT_W + (x_s - xi_s);
        en_d   = 1'b1;
        sel_d  = bcd_q[4*(NUM_DIGITS-1-i) +: 4];
        addr_d = ADDR_W'(off_s);
      end else begin
        en_d = en_d;
      end
    end
  end

  // State update; tick history is tracked on every non-reset cycle.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      bcd_q       <= '0;
      terminal_q  <= 1'b0;
      tick_prev_q <= 1'b0;
      sel_q       <= 4'd0;
      addr_q      <= '0;
      en_q        <= 1'b0;
    end else begin
      bcd_q       <= bcd_d;
      terminal_q  <= terminal_d;
      tick_prev_q <= tick;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
    end
  end

  assign bcd_value       = bcd_q;
  assign terminal        = terminal_q;
  assign selected_number = sel_q;
  assign glyph_addr      = addr_q;
  assign en_digit        = en_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: three instances (wrap, saturate, leading-zero
// blanking) share stimulus and are checked against an integer-valued model.
module tb_bcd_counter_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        tick = 1'b0;
  logic        count_down = 1'b0;
  logic        hold = 1'b0;
  logic [11:0] load_value = 12'h000;
  logic [9:0]  X = 10'd0;
  logic [9:0]  Y = 10'd0;

  logic [11:0] bcd_o  [3];
  logic        term_o [3];
  logic [3:0]  sel_o  [3];
  logic [7:0]  addr_o [3];
  logic        en_o   [3];

  int errors = 0;
  int checks = 0;

  // Model: counter value as a plain integer 0..999, plus expected render outputs.
  int          mv [3];
  logic        mt [3];
  logic [3:0]  es [3];
  logic [7:0]  ea [3];
  logic        ee [3];
  logic        mprev = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_display dut0 (
    .clock_25(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .tick(tick), .count_down(count_down), .hold(hold), .X(X), .Y(Y),
    .bcd_value(bcd_o[0]), .terminal(term_o[0]), .selected_number(sel_o[0]),
    .glyph_addr(addr_o[0]), .en_digit(en_o[0]));

  bcd_counter_display #(.SATURATE(1)) dut1 (
    .clock_25(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .tick(tick), .count_down(count_down), .hold(hold), .X(X), .Y(Y),
    .bcd_value(bcd_o[1]), .terminal(term_o[1]), .selected_number(sel_o[1]),
    .glyph_addr(addr_o[1]), .en_digit(en_o[1]));

  bcd_counter_display #(.BLANK_LEADING(1)) dut2 (
    .clock_25(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .tick(tick), .count_down(count_down), .hold(hold), .X(X), .Y(Y),
    .bcd_value(bcd_o[2]), .terminal(term_o[2]), .selected_number(sel_o[2]),
    .glyph_addr(addr_o[2]), .en_digit(en_o[2]));

  function automatic int p10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clamp_val(input logic [11:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = 0; i < 3; i++) begin
      d = int'(lv[4*(2-i) +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Which box the beam is in, from box geometry and decimal digits of v.
  task automatic render_model(input int v, input bit blk,
                              output logic [3:0] s, output logic [7:0] a, output logic e);
    int x;
    int y;
    int xi;
    int p;
    x = int'(X);
    y = int'(Y);
    s = 4'd0;
    a = 8'd0;
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xi = 179 + i * 14;
      p  = p10(2 - i);
      if (x >= xi && x <= xi + 11 && y >= 466 && y <= 475) begin
        if (!(blk && i != 2 && v < p)) begin
          e = 1'b1;
          s = 4'((v / p) % 10);
          a = 8'((y - 466) * 12 + (x - xi));
        end
      end
    end
  endtask

  // Advance the model with the inputs now applied, then clock and settle.
  task automatic advance();
    logic       stp;
    logic [3:0] s;
    logic [7:0] a;
    logic       e;
    stp = tick && !mprev && !hold;
    for (int k = 0; k < 3; k++) begin
      render_model(mv[k], (k == 2), s, a, e);
      if (reset) begin
        mv[k] = 0; mt[k] = 1'b0; es[k] = 4'd0; ea[k] = 8'd0; ee[k] = 1'b0;
      end else begin
        es[k] = s; ea[k] = a; ee[k] = e; mt[k] = 1'b0;
        if (clear) mv[k] = 0;
        else if (load) mv[k] = clamp_val(load_value);
        else if (stp) begin
          if (!count_down) begin
            if (mv[k] == 999) begin
              if (k != 1) mv[k] = 0;
            end else begin
              mv[k] = mv[k] + 1;
              mt[k] = (mv[k] == 999);
            end
          end else begin
            if (mv[k] == 0) begin
              if (k != 1) mv[k] = 999;
            end else begin
              mv[k] = mv[k] - 1;
              mt[k] = (mv[k] == 0);
            end
          end
        end
      end
    end
    mprev = reset ? 1'b0 : tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    advance();
    advance();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bcd_o[k], term_o[k], sel_o[k], addr_o[k], en_o[k]} !== 26'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got bcd=%h t=%b s=%0d a=%0d e=%b, expected all 0",
                 k, bcd_o[k], term_o[k], sel_o[k], addr_o[k], en_o[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_up_wrap();
    count_down = 1'b0;
    load = 1'b1; load_value = 12'h998;
    advance();
    load = 1'b0;
    checks++;
    if (bcd_o[0] !== 12'h998) begin
      errors++; $display("FAIL up_load: got %h expected 998", bcd_o[0]);
    end
    tick = 1'b1; advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bcd_o[k] !== 12'h999 || term_o[k] !== 1'b1) begin
        errors++; $display("FAIL up_edge1 dut%0d: got %h t=%b expected 999 t=1", k, bcd_o[k], term_o[k]);
      end
    end
    tick = 1'b0; advance();
    checks++;
    if (term_o[0] !== 1'b0) begin
      errors++; $display("FAIL up_pulse_width: got t=%b expected 0", term_o[0]);
    end
    tick = 1'b1; advance();
    checks++;
    if (bcd_o[0] !== 12'h000 || term_o[0] !== 1'b0) begin
      errors++; $display("FAIL up_wrap: got %h t=%b expected 000 t=0", bcd_o[0], term_o[0]);
    end
    checks++;
    if (bcd_o[1] !== 12'h999 || term_o[1] !== 1'b0) begin
      errors++; $display("FAIL up_sat: got %h t=%b expected 999 t=0", bcd_o[1], term_o[1]);
    end
    tick = 1'b0; advance();
    tick = 1'b1;
    repeat (5) advance();
    tick = 1'b0; advance();
    checks++;
    if (bcd_o[0] !== 12'h001) begin
      errors++; $display("FAIL up_level_held: got %h expected 001", bcd_o[0]);
    end
  endtask

  task automatic test_down_sat();
    logic [11:0] exp1 [3];
    logic        expt [3];
    count_down = 1'b1;
    load = 1'b1; load_value = 12'h002;
    advance();
    load = 1'b0;
    exp1[0] = 12'h001; exp1[1] = 12'h000; exp1[2] = 12'h000;
    expt[0] = 1'b0;    expt[1] = 1'b1;    expt[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick = 1'b1; advance();
      checks++;
      if (bcd_o[1] !== exp1[n] || term_o[1] !== expt[n]) begin
        errors++;
        $display("FAIL down_sat edge%0d: got %h t=%b expected %h t=%b", n, bcd_o[1], term_o[1], exp1[n], expt[n]);
      end
      tick = 1'b0; advance();
    end
    checks++;
    if (bcd_o[0] !== 12'h999 || mv[0] != 999) begin
      errors++; $display("FAIL down_wrap: got %h expected 999", bcd_o[0]);
    end
    load = 1'b1; load_value = 12'hA5F;
    advance();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bcd_o[k] !== 12'h959) begin
        errors++; $display("FAIL load_clamp dut%0d: got %h expected 959", k, bcd_o[k]);
      end
    end
  endtask

  task automatic test_priority();
    count_down = 1'b0;
    tick = 1'b0; advance();
    load = 1'b1; load_value = 12'h123; tick = 1'b1;
    advance();
    load = 1'b0; tick = 1'b0;
    checks++;
    if (bcd_o[0] !== 12'h123) begin
      errors++; $display("FAIL prio_load: got %h expected 123", bcd_o[0]);
    end
    advance();
    hold = 1'b1; tick = 1'b1; advance();
    hold = 1'b0; advance();
    tick = 1'b0; advance();
    checks++;
    if (bcd_o[0] !== 12'h123) begin
      errors++; $display("FAIL prio_hold: got %h expected 123", bcd_o[0]);
    end
    clear = 1'b1; tick = 1'b1; advance();
    clear = 1'b0; tick = 1'b0;
    checks++;
    if (bcd_o[0] !== 12'h000) begin
      errors++; $display("FAIL prio_clear: got %h expected 000", bcd_o[0]);
    end
    load = 1'b1; load_value = 12'h998; advance();
    load = 1'b0; advance();
    reset = 1'b1; tick = 1'b1; advance();
    reset = 1'b0; tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bcd_o[k] !== 12'h000 || term_o[k] !== 1'b0) begin
        errors++; $display("FAIL prio_reset dut%0d: got %h t=%b expected 000 t=0", k, bcd_o[k], term_o[k]);
      end
    end
    advance();
  endtask

  task automatic test_render();
    int          px [4];
    int          py [4];
    logic [3:0]  xs [4];
    logic [7:0]  xa [4];
    logic        xe [4];
    px[0] = 179; py[0] = 466; xs[0] = 4'd4; xa[0] = 8'd0;   xe[0] = 1'b1;
    px[1] = 204; py[1] = 475; xs[1] = 4'd0; xa[1] = 8'd119; xe[1] = 1'b1;
    px[2] = 191; py[2] = 470; xs[2] = 4'd0; xa[2] = 8'd0;   xe[2] = 1'b0;
    px[3] = 207; py[3] = 466; xs[3] = 4'd7; xa[3] = 8'd0;   xe[3] = 1'b1;
    load = 1'b1; load_value = 12'h407; advance();
    load = 1'b0;
    for (int n = 0; n < 4; n++) begin
      X = 10'(px[n]); Y = 10'(py[n]);
      advance();
      checks++;
      if (sel_o[0] !== xs[n] || addr_o[0] !== xa[n] || en_o[0] !== xe[n]) begin
        errors++;
        $display("FAIL render pos%0d: got s=%0d a=%0d e=%b expected s=%0d a=%0d e=%b",
                 n, sel_o[0], addr_o[0], en_o[0], xs[n], xa[n], xe[n]);
      end
    end
  endtask

  task automatic test_blank();
    load = 1'b1; load_value = 12'h007; advance();
    load = 1'b0;
    X = 10'd179; Y = 10'd466; advance();
    checks++;
    if (en_o[2] !== 1'b0 || en_o[0] !== 1'b1 || sel_o[0] !== 4'd0) begin
      errors++; $display("FAIL blank_box0: got e2=%b e0=%b s0=%0d expected e2=0 e0=1 s0=0", en_o[2], en_o[0], sel_o[0]);
    end
    X = 10'd193; advance();
    checks++;
    if (en_o[2] !== 1'b0 || sel_o[2] !== 4'd0 || addr_o[2] !== 8'd0) begin
      errors++; $display("FAIL blank_box1: got e=%b s=%0d a=%0d expected e=0 s=0 a=0", en_o[2], sel_o[2], addr_o[2]);
    end
    X = 10'd210; Y = 10'd470; advance();
    checks++;
    if (en_o[2] !== 1'b1 || sel_o[2] !== 4'd7 || addr_o[2] !== 8'd51) begin
      errors++; $display("FAIL blank_box2: got e=%b s=%0d a=%0d expected e=1 s=7 a=51", en_o[2], sel_o[2], addr_o[2]);
    end
    clear = 1'b1; advance();
    clear = 1'b0; X = 10'd207; Y = 10'd466; advance();
    checks++;
    if (en_o[2] !== 1'b1 || sel_o[2] !== 4'd0) begin
      errors++; $display("FAIL blank_zero_lsd: got e=%b s=%0d expected e=1 s=0", en_o[2], sel_o[2]);
    end
  endtask

  task automatic test_reset_mid();
    count_down = 1'b0;
    load = 1'b1; load_value = 12'h456; advance();
    load = 1'b0; X = 10'd195; Y = 10'd470; advance();
    checks++;
    if (en_o[0] !== 1'b1 || sel_o[0] !== 4'd5 || addr_o[0] !== 8'd50) begin
      errors++; $display("FAIL mid_pre: got e=%b s=%0d a=%0d expected e=1 s=5 a=50", en_o[0], sel_o[0], addr_o[0]);
    end
    reset = 1'b1; tick = 1'b1; advance();
    checks++;
    if ({bcd_o[0], term_o[0], sel_o[0], addr_o[0], en_o[0]} !== 26'd0) begin
      errors++; $display("FAIL mid_reset: got bcd=%h s=%0d a=%0d e=%b expected all 0", bcd_o[0], sel_o[0], addr_o[0], en_o[0]);
    end
    reset = 1'b0; advance();
    checks++;
    if (bcd_o[0] !== 12'h001 || en_o[0] !== 1'b1 || sel_o[0] !== 4'd0 || addr_o[0] !== 8'd50) begin
      errors++; $display("FAIL mid_resume: got bcd=%h e=%b s=%0d a=%0d expected 001 e=1 s=0 a=50",
                         bcd_o[0], en_o[0], sel_o[0], addr_o[0]);
    end
    advance();
    tick = 1'b0;
    checks++;
    if (bcd_o[0] !== 12'h001) begin
      errors++; $display("FAIL mid_one_step: got %h expected 001", bcd_o[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      clear      = ($urandom_range(0, 31) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_value = 12'($urandom);
      tick       = 1'($urandom);
      hold       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) count_down = ~count_down;
      X = 10'($urandom_range(170, 230));
      Y = 10'($urandom_range(462, 479));
      advance();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (bcd_o[k] !== to_bcd(mv[k]) || term_o[k] !== mt[k] || sel_o[k] !== es[k] ||
            addr_o[k] !== ea[k] || en_o[k] !== ee[k]) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got bcd=%h t=%b s=%0d a=%0d e=%b expected bcd=%h t=%b s=%0d a=%0d e=%b",
                   k, c, bcd_o[k], term_o[k], sel_o[k], addr_o[k], en_o[k],
                   to_bcd(mv[k]), mt[k], es[k], ea[k], ee[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; mt[k] = 1'b0; es[k] = 4'd0; ea[k] = 8'd0; ee[k] = 1'b0;
    end
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_priority();
    test_render();
    test_blank();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parametrised successor to the HUD time/score digit controller.
- Holds an NUM_DIGITS-wide BCD counter that steps on rising edges of a tick input. It can count up or down, can be paused and can be loaded, and either wraps or saturates at its terminal value.
- In parallel it maps the VGA scan position (X,Y) to the digit under the beam. It outputs that digit's value, a glyph-ROM address and an enable, for the shared digit-glyph ROM and pixel mux.

Parameters:
- PIXEL_DISPLAY_BIT, 9, MSB index of X/Y (coordinate width = PIXEL_DISPLAY_BIT+1).
- NUM_DIGITS, 3, number of BCD digits (1..8).
- X0, 179, left pixel column of the most-significant digit box.
- Y0, 466, top pixel row of all digit boxes.
- DIGIT_W, 12, digit box width in pixels.
- DIGIT_H, 10, digit box height in pixels.
- GAP, 2, blank columns between adjacent digit boxes.
- ADDR_W, 8, glyph address width (must hold DIGIT_W*DIGIT_H-1).
- SATURATE, 0, 0 = wrap at terminal value, 1 = stick at terminal value.
- BLANK_LEADING, 0, 1 = suppress leading-zero digits (the least-significant digit is never blanked).

Ports:
- clock_25, in, 1, pixel clock.
- reset, in, 1, synchronous, active-high.
- clear, in, 1, synchronous counter clear to zero.
- load, in, 1, synchronous load of load_value.
- load_value, in, 4*NUM_DIGITS, BCD load value; the MS digit is in the top nibble.
- tick, in, 1, count event level; its rising edge requests one step.
- count_down, in, 1, 0 = increment, 1 = decrement.
- hold, in, 1, pause; edges seen while high are discarded.
- X, in, PIXEL_DISPLAY_BIT+1, current scan column.
- Y, in, PIXEL_DISPLAY_BIT+1, current scan row.
- bcd_value, out, 4*NUM_DIGITS, current counter value.
- terminal, out, 1, one-cycle pulse when a step lands on the terminal value.
- selected_number, out, 4, BCD digit under the beam.
- glyph_addr, out, ADDR_W, pixel index inside the digit box.
- en_digit, out, 1, the beam is inside a visible digit box.

Behaviour:
- Reset (checked at the clock edge) clears:
  - bcd_value, terminal, selected_number, glyph_addr and en_digit to 0.
  - tick_prev to 0.
- Edge detection: tick_prev <= tick every non-reset cycle, including cycles with clear or load. A step is requested when tick & ~tick_prev.
- Counter priority, highest first: reset > clear > load > step.
  - A step requested in the same cycle as clear or load is discarded.
  - A step requested while hold=1 is discarded; it is not deferred.
- Load: each nibble greater than 9 is clamped to 9.
- Up step: ripple BCD increment, where digit i carries into digit i-1 when it passes 9->0.
  - Terminal value is all 9s.
  - At all 9s: SATURATE=0 wraps to all 0s; SATURATE=1 leaves the value unchanged.
- Down step: ripple BCD decrement, where a 0->9 borrow propagates.
  - Terminal value is all 0s.
  - At all 0s: SATURATE=0 wraps to all 9s; SATURATE=1 leaves the value unchanged.
- terminal: high for exactly one cycle after an accepted step whose result equals the terminal value for the current count_down.
  - Not asserted by clear or load.
  - Not asserted by a saturated step that leaves the value unchanged.
- count_down may change on any cycle and takes effect on the next step.
- Render path, one cycle of latency (registered outputs):
  - Digit box i (i=0 is most significant) is xi = X0 + i*(DIGIT_W+GAP) <= X <= xi+DIGIT_W-1, with Y0 <= Y <= Y0+DIGIT_H-1.
  - Inside box i:
    - en_digit=1.
    - selected_number = nibble i of bcd_value as held in the sampling cycle.
    - glyph_addr = (Y-Y0)*DIGIT_W + (X-xi), truncated to ADDR_W.
  - Outside every box, including gap columns: en_digit=0, selected_number=0, glyph_addr=0.
- Leading-zero blanking: when BLANK_LEADING=1, digit i is blanked if it and all more-significant digits are 0 and i is not NUM_DIGITS-1. A blanked digit produces outside-box outputs.
- Implementation uses comparators on X/Y only; no per-line accumulated state. Renders are correct for any scan order.
- Reset mid-frame: the outputs are 0 in the following cycle; rendering resumes correctly on the next cycle with no frame resync.

Test Plan:
1. Up count with NUM_DIGITS=3, SATURATE=0: load 998, apply 2 tick edges -> bcd_value 999 with terminal pulse after the first edge, then 000 with no pulse. Tick held high for 5 cycles -> exactly one step.
2. Down count with SATURATE=1, count_down=1: load 002, apply 3 edges -> 001, 000 (terminal pulse), 000 (no pulse). Load 0xA5F -> bcd_value 959.
3. Priority: tick edge coincident with load of 123 -> 123, not 124. Edge with hold=1 -> no change. Edge with clear -> 000. Edge coincident with reset -> 000 and terminal=0.
4. Render with value 407 and default geometry:
   - (X=179,Y=466) -> next cycle selected_number=4, glyph_addr=0, en=1.
   - (X=204,Y=475) -> 0, glyph_addr=119, en=1.
   - (X=191,Y=470) -> en=0.
   - (X=207,Y=466) -> selected_number=7.
5. BLANK_LEADING=1 with value 007: boxes 0 and 1 -> en_digit=0; box 2 -> selected_number=7, en=1. With value 000, box 2 -> en=1, selected_number=0.
6. Reset asserted mid-scan inside box 1 -> all outputs 0 next cycle. Counter at 000 and tick_prev cleared, so a tick already high at reset release counts one step.
